// File: rtl/edge_detect_sequencer_if.sv
// edge_detect_sequencer_if: pixel stream, detector control and packed edge stream bundle
interface edge_detect_sequencer_if #(parameter int PIX_W = 8);
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] det_in;
  logic             det_enb;
  logic             det_mode_buffer;
  logic             det_reset;
  logic             det_reset_buff;
  logic             det_edge;
  logic             det_complete;
  logic [7:0]       edge_byte;
  logic             edge_valid;
  logic             edge_ready;
  modport slave (
    input  pix_data, pix_valid, det_edge, det_complete, edge_ready,
    output pix_ready, det_in, det_enb, det_mode_buffer, det_reset, det_reset_buff, edge_byte, edge_valid
  );
  modport master (
    output pix_data, pix_valid, det_edge, det_complete, edge_ready,
    input  pix_ready, det_in, det_enb, det_mode_buffer, det_reset, det_reset_buff, edge_byte, edge_valid
  );
endinterface

// File: rtl/edge_detect_sequencer.sv
// edge_detect_sequencer: loads a frame into the edge detector, then drains and byte-packs its edge bits
module edge_detect_sequencer #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  edge_detect_sequencer_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int NUM_PIXELS = IMG_W * IMG_H;
  localparam int CW = $clog2(NUM_PIXELS + 1);
  localparam logic [CW-1:0] NP = CW'(NUM_PIXELS);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, GAP, DRAIN, FLUSH, DONE} state_t;
  state_t        state;
  logic [CW-1:0] pix_cnt, bit_cnt;
  logic [7:0]    pack, next_pack;
  logic          flushed, drain_en, byte_full, free, need;
  always_comb begin
    drain_en  = state == DRAIN && !bus.det_complete && bit_cnt < NP && !(bus.edge_valid && !bus.edge_ready);
    byte_full = drain_en && bit_cnt[2:0] == 3'd7;
    next_pack = pack | (8'(bus.det_edge) << bit_cnt[2:0]);
    free      = !bus.edge_valid || bus.edge_ready;
    need      = bit_cnt[2:0] != 3'd0 && !flushed;
    bus.det_in  = state == LOAD ? bus.pix_data : '0;
    bus.det_enb = state == LOAD ? bus.pix_valid : drain_en;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      pix_cnt             <= '0;
      bit_cnt             <= '0;
      pack                <= '0;
      flushed             <= 1'b0;
      bus.pix_ready       <= 1'b0;
      bus.det_mode_buffer <= 1'b0;
      bus.det_reset       <= 1'b1;
      bus.det_reset_buff  <= 1'b1;
      bus.edge_byte       <= '0;
      bus.edge_valid      <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      err                 <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.edge_valid && bus.edge_ready) bus.edge_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= CLEAR;
          busy    <= 1'b1;
          err     <= 1'b0;
          pix_cnt <= '0;
          bit_cnt <= '0;
          pack    <= '0;
          flushed <= 1'b0;
        end
        CLEAR: begin
          state              <= LOAD;
          bus.pix_ready      <= 1'b1;
          bus.det_reset      <= 1'b0;
          bus.det_reset_buff <= 1'b0;
        end
        LOAD: if (bus.pix_valid) begin
          pix_cnt <= pix_cnt + 1'b1;
          if (pix_cnt == NP - 1'b1) begin
            state         <= GAP;
            bus.pix_ready <= 1'b0;
          end
        end
        GAP: begin
          state               <= DRAIN;
          bus.det_mode_buffer <= 1'b1;
        end
        DRAIN: begin
          if (drain_en) begin
            bit_cnt <= bit_cnt + 1'b1;
            pack    <= byte_full ? 8'h00 : next_pack;
          end
          if (byte_full) begin
            bus.edge_byte  <= next_pack;
            bus.edge_valid <= 1'b1;
          end
          if (bus.det_complete) begin
            state <= FLUSH;
            if (bit_cnt < NP) err <= 1'b1;
          end
        end
        // a partial byte goes out first; DONE follows once the output slot is free again
        FLUSH: if (free) begin
          if (need) begin
            bus.edge_byte  <= pack;
            bus.edge_valid <= 1'b1;
            pack           <= '0;
            flushed        <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state               <= IDLE;
          busy                <= 1'b0;
          bus.det_reset       <= 1'b1;
          bus.det_reset_buff  <= 1'b1;
          bus.det_mode_buffer <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_edge_detect_sequencer.sv
// tb_edge_detect_sequencer: directed vector table plus hand-built corner sequences on a 4x4 frame
module tb_edge_detect_sequencer;
  localparam int N = 16;
  typedef struct {
    logic        start, pv;
    logic [7:0]  pd;
    logic        de, dc, er;
    logic [24:0] exp;
  } vec_t;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic busy, done, err;
  int   total = 0, bad = 0;
  vec_t tbl[$];
  edge_detect_sequencer_if #(.PIX_W(8)) bus();
  edge_detect_sequencer #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  function automatic logic [24:0] e(input logic pr, en, input logic [7:0] din, input logic mode, rst, ev,
                                    input logic [7:0] eb, input logic bz, dn, er);
    return {pr, en, din, mode, rst, rst, ev, eb, bz, dn, er};
  endfunction
  function automatic logic [24:0] obs();
    return {bus.pix_ready, bus.det_enb, bus.det_in, bus.det_mode_buffer, bus.det_reset, bus.det_reset_buff,
            bus.edge_valid, bus.edge_valid ? bus.edge_byte : 8'h00, busy, done, err};
  endfunction
  function automatic void add(input logic s, pv, input logic [7:0] pd, input logic de, dc, er, input logic [24:0] x);
    vec_t v;
    v.start = s; v.pv = pv; v.pd = pd; v.de = de; v.dc = dc; v.er = er; v.exp = x;
    tbl.push_back(v);
  endfunction
  task automatic chk(input string nm, input logic [24:0] x);
    total++;
    if (obs() !== x) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, obs(), x);
    end
  endtask
  task automatic chkv(input string nm, input int act, input int x);
    total++;
    if (act != x) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, x);
    end
  endtask
  task automatic drv(input logic s, pv, input logic [7:0] pd, input logic de, dc, er);
    @(negedge clk);
    start = s; bus.pix_valid = pv; bus.pix_data = pd;
    bus.det_edge = de; bus.det_complete = dc; bus.edge_ready = er;
    #1;
  endtask
  task automatic feed_pixels();
    for (int i = 0; i < N; i++) drv(0, 1, 8'(i), 0, 0, 1);
    drv(0, 0, 8'h00, 0, 0, 1);
  endtask
  task automatic drain(input logic [7:0] byt, input int n);
    for (int k = 0; k < n; k++) begin
      drv(0, 0, 8'h00, byt[k], 0, 1);
      chkv("drain_enb", int'(bus.det_enb), 1);
    end
  endtask
  initial begin
    logic [15:0] bits;
    int acc;
    bits = 16'hFE8D;
    bus.pix_valid = 0; bus.pix_data = 0; bus.det_edge = 0; bus.det_complete = 0; bus.edge_ready = 0;
    // frame with no bubbles and a free-running consumer
    add(1, 0, 8'h00, 0, 0, 1, e(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    add(0, 0, 8'h00, 0, 0, 1, e(0, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 0));
    for (int i = 0; i < N; i++)
      add(0, 1, 8'(8'h40 + i), 0, 0, 1, e(1, 1, 8'(8'h40 + i), 0, 0, 0, 8'h00, 1, 0, 0));
    add(0, 1, 8'hAA, 0, 0, 1, e(0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0));
    for (int k = 0; k < N; k++)
      add(0, 1, 8'hAA, bits[k], 0, 1, e(0, 1, 8'h00, 1, 0, k == 8, k == 8 ? 8'h8D : 8'h00, 1, 0, 0));
    add(0, 0, 8'h00, 0, 0, 0, e(0, 0, 8'h00, 1, 0, 1, 8'hFE, 1, 0, 0));
    add(0, 0, 8'h00, 0, 1, 0, e(0, 0, 8'h00, 1, 0, 1, 8'hFE, 1, 0, 0));
    add(0, 0, 8'h00, 0, 0, 1, e(0, 0, 8'h00, 1, 0, 1, 8'hFE, 1, 0, 0));
    add(0, 0, 8'h00, 0, 0, 1, e(0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 1, 0));
    add(0, 0, 8'h00, 0, 0, 1, e(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    repeat (2) @(negedge clk);
    #1 chk("reset", e(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      drv(tbl[i].start, tbl[i].pv, tbl[i].pd, tbl[i].de, tbl[i].dc, tbl[i].er);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end
    // bubbles on the pixel stream: det_enb tracks pix_valid, 16 accepts, then GAP
    drv(1, 0, 8'h00, 0, 0, 1);
    drv(0, 0, 8'h00, 0, 0, 1);
    acc = 0;
    for (int i = 0; i < 2 * N - 1; i++) begin
      drv(0, (i % 2) == 0, 8'(i), 0, 0, 1);
      if (bus.pix_ready && bus.pix_valid) acc++;
      chk($sformatf("bub%0d", i), e(1, (i % 2) == 0, (i % 2) == 0 ? 8'(i) : 8'(i), 0, 0, 0, 8'h00, 1, 0, 0));
    end
    chkv("bub_accepted", acc, N);
    drv(0, 1, 8'h55, 0, 0, 1);
    chk("bub_gap", e(0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0));
    // backpressure: stall with 0x8D pending, garbage det_edge must not be sampled
    drain(8'h8D, 8);
    for (int j = 0; j < 5; j++) begin
      drv(0, 0, 8'h00, 1, 0, 0);
      chk($sformatf("stall%0d", j), e(0, 0, 8'h00, 1, 0, 1, 8'h8D, 1, 0, 0));
    end
    drain(8'hFE, 8);
    drv(0, 0, 8'h00, 1, 0, 0);
    chk("bp_full", e(0, 0, 8'h00, 1, 0, 1, 8'hFE, 1, 0, 0));
    drv(0, 0, 8'h00, 0, 1, 1);
    chk("bp_complete", e(0, 0, 8'h00, 1, 0, 1, 8'hFE, 1, 0, 0));
    drv(0, 0, 8'h00, 0, 0, 1);
    chk("bp_flush", e(0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 0));
    drv(0, 0, 8'h00, 0, 0, 1);
    chk("bp_done", e(0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 1, 0));
    drv(0, 0, 8'h00, 0, 0, 1);
    chk("bp_idle", e(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    // early complete after 12 bits: partial byte 0x0D, sticky err
    drv(1, 0, 8'h00, 0, 0, 1);
    drv(0, 0, 8'h00, 0, 0, 1);
    feed_pixels();
    drain(8'h8D, 8);
    drain(8'h0D, 4);
    drv(0, 0, 8'h00, 1, 1, 1);
    chk("early_complete", e(0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 0));
    drv(0, 0, 8'h00, 0, 0, 1);
    chk("early_flush", e(0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 1));
    drv(0, 0, 8'h00, 0, 0, 1);
    chk("early_byte", e(0, 0, 8'h00, 1, 0, 1, 8'h0D, 1, 0, 1));
    drv(0, 0, 8'h00, 0, 0, 1);
    chk("early_done", e(0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 1, 1));
    drv(0, 0, 8'h00, 0, 0, 1);
    chk("early_idle", e(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1));
    drv(1, 0, 8'h00, 0, 0, 1);
    chk("rerun_start", e(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1));
    drv(0, 0, 8'h00, 0, 0, 1);
    chk("rerun_clear", e(0, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 0));
    feed_pixels();
    drain(8'h8D, 3);
    @(negedge clk);
    bus.det_edge = 1'b1; bus.pix_data = 8'h77;
    #2 reset = 1'b0;
    #1 chk("async_reset", e(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    @(negedge clk) reset = 1'b1;
    drv(0, 1, 8'h33, 0, 0, 1);
    chk("post_reset_idle", e(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
